// File: rtl/hack_boot_loader_pkg.sv
// rtl/hack_boot_loader_pkg.sv - shared state encoding and defaults for the Hack boot loader
package hack_boot_loader_pkg;

    localparam int ADDR_W_DEFAULT = 15;

    typedef enum logic [2:0] {
        LEN_LO  = 3'd0,
        LEN_HI  = 3'd1,
        DATA_LO = 3'd2,
        DATA_HI = 3'd3,
        CHK_LO  = 3'd4,
        CHK_HI  = 3'd5,
        RUN     = 3'd6,
        ERROR   = 3'd7
    } bootState_t;

    function automatic logic isLoading(bootState_t s);
        return (s != RUN) && (s != ERROR);
    endfunction

    // Every field of the stream is a little-endian pair; these states take the low byte.
    function automatic logic isLowByte(bootState_t s);
        return (s == LEN_LO) || (s == DATA_LO) || (s == CHK_LO);
    endfunction

endpackage

// File: rtl/boot_word_assembler.sv
// rtl/boot_word_assembler.sv - pairs a latched low byte with the live high byte into a 16-bit word
module boot_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        loStrobe,
    input  logic        hiStrobe,
    input  logic [7:0]  byteIn,
    output logic [15:0] word,
    output logic        wordValid
);

    logic [7:0] loReg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            loReg <= 8'h00;
        end else if (loStrobe) begin
            loReg <= byteIn;
        end
    end

    // The word is presented in the same cycle as the high byte so the FSM can act on it at that edge.
    assign word      = {byteIn, loReg};
    assign wordValid = hiStrobe;

endmodule

// File: rtl/hack_boot_loader.sv
// rtl/hack_boot_loader.sv - loads a length/data/checksum byte stream into instruction memory, then releases the CPU
module hack_boot_loader
    import hack_boot_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              boot_req,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_wdata,
    output logic              rom_we,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    bootState_t      state;
    bootState_t      nextState;
    logic [ADDR_W:0] wordIdx;
    logic [15:0]     lenReg;
    logic [15:0]     acc;
    logic            xfer;
    logic            loStrobe;
    logic            hiStrobe;
    logic [15:0]     word;
    logic            wordValid;
    logic            tooLong;
    logic            lastWord;
    logic            restart;
    logic            lenCapture;
    logic            dataCapture;

    assign rx_ready = isLoading(state);
    assign xfer     = rx_valid && rx_ready;
    assign loStrobe = xfer && isLowByte(state);
    assign hiStrobe = xfer && !isLowByte(state);

    boot_word_assembler u_assembler (
        .clk       (clk),
        .reset     (reset),
        .loStrobe  (loStrobe),
        .hiStrobe  (hiStrobe),
        .byteIn    (rx_data),
        .word      (word),
        .wordValid (wordValid)
    );

    // The index is one bit wider than the address so a full-capacity image ends without wrapping.
    assign tooLong     = 32'(word) > (32'd1 << ADDR_W);
    assign lastWord    = (32'(wordIdx) + 32'd1) == 32'(lenReg);
    assign restart     = boot_req && !isLoading(state);
    assign lenCapture  = (state == LEN_HI) && wordValid;
    assign dataCapture = (state == DATA_HI) && wordValid;

    always_comb begin
        nextState = state;
        case (state)
            LEN_LO:  if (xfer) nextState = LEN_HI;
            LEN_HI:  if (wordValid) nextState = tooLong ? ERROR : ((word == 16'h0000) ? CHK_LO : DATA_LO);
            DATA_LO: if (xfer) nextState = DATA_HI;
            DATA_HI: if (wordValid) nextState = lastWord ? CHK_LO : DATA_LO;
            CHK_LO:  if (xfer) nextState = CHK_HI;
            CHK_HI:  if (wordValid) nextState = (word == acc) ? RUN : ERROR;
            RUN:     if (boot_req) nextState = LEN_LO;
            ERROR:   if (boot_req) nextState = LEN_LO;
            default: nextState = LEN_LO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= LEN_LO;
            wordIdx   <= '0;
            lenReg    <= 16'h0000;
            acc       <= 16'h0000;
            rom_we    <= 1'b0;
            rom_addr  <= '0;
            rom_wdata <= 16'h0000;
            cpu_reset <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= nextState;
            cpu_reset <= (nextState != RUN);
            busy      <= isLoading(nextState);
            done      <= (nextState == RUN);
            error     <= (nextState == ERROR);
            rom_we    <= 1'b0;
            if (restart || lenCapture) begin
                wordIdx <= '0;
                acc     <= 16'h0000;
            end
            if (lenCapture) begin
                lenReg <= word;
            end
            if (dataCapture) begin
                rom_we    <= 1'b1;
                rom_addr  <= wordIdx[ADDR_W-1:0];
                rom_wdata <= word;
                acc       <= acc + word;
                wordIdx   <= wordIdx + (ADDR_W+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_hack_boot_loader.sv
// tb/tb_hack_boot_loader.sv - randomized self-checking bench for hack_boot_loader
module tb_hack_boot_loader;

    localparam int ADDR_W = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              boot_req;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_wdata;
    logic              rom_we;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;

    hack_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .boot_req  (boot_req),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .rom_we    (rom_we),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] curWords[$];
    logic [7:0]  txBytes[$];
    logic [31:0] obsWrites[$];
    logic [31:0] expWrites[$];
    logic        readyOk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rom_we === 1'b1) obsWrites.push_back({1'b0, rom_addr, rom_wdata});
    end

    function automatic logic [15:0] imageSum();
        int s = 0;
        foreach (curWords[i]) s += int'(curWords[i]);
        return 16'(s % 65536);
    endfunction

    task automatic buildStream(input logic [15:0] n, input logic [15:0] chk);
        txBytes.delete();
        txBytes.push_back(n[7:0]);
        txBytes.push_back(n[15:8]);
        foreach (curWords[i]) begin
            txBytes.push_back(curWords[i][7:0]);
            txBytes.push_back(curWords[i][15:8]);
        end
        txBytes.push_back(chk[7:0]);
        txBytes.push_back(chk[15:8]);
    endtask

    task automatic sendBytes(input int gapMax, input string tag);
        readyOk = 1'b1;
        foreach (txBytes[i]) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(gapMax, 0)) begin
                @(posedge clk); #1;
                if (rx_ready !== 1'b1) readyOk = 1'b0;
            end
            rx_valid = 1'b1;
            rx_data  = txBytes[i];
            if (rx_ready !== 1'b1) readyOk = 1'b0;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        boot_req = 1'b0;
        checkEq({tag, ".readyDuringLoad"}, readyOk, 1'b1);
    endtask

    task automatic compareWrites(input string tag);
        checkEq({tag, ".writeCount"}, obsWrites.size(), expWrites.size());
        foreach (expWrites[i]) begin
            if (i < obsWrites.size()) checkEq({tag, ".write"}, obsWrites[i], expWrites[i]);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkEq({tag, ".cpu_reset"}, cpu_reset, 1'b1);
        checkEq({tag, ".rom_we"}, rom_we, 1'b0);
        checkEq({tag, ".rom_addr"}, rom_addr, 0);
        checkEq({tag, ".rom_wdata"}, rom_wdata, 0);
        checkEq({tag, ".busy"}, busy, 1'b1);
        checkEq({tag, ".done"}, done, 1'b0);
        checkEq({tag, ".error"}, error, 1'b0);
        checkEq({tag, ".rx_ready"}, rx_ready, 1'b1);
    endtask

    // Reference: the image is good iff the modular word sum equals CHK; word i lands at address i.
    task automatic loadAndCheck(input string tag, input logic [15:0] chk, input int gapMax);
        logic expOk;
        expOk = (imageSum() == chk);
        expWrites.delete();
        foreach (curWords[i]) expWrites.push_back({1'b0, 15'(i), curWords[i]});
        obsWrites.delete();
        buildStream(16'(curWords.size()), chk);
        sendBytes(gapMax, tag);
        checkEq({tag, ".done"}, done, expOk);
        checkEq({tag, ".error"}, error, !expOk);
        checkEq({tag, ".cpu_reset"}, cpu_reset, !expOk);
        checkEq({tag, ".busy"}, busy, 1'b0);
        checkEq({tag, ".rx_ready"}, rx_ready, 1'b0);
        @(negedge clk); #1;
        compareWrites(tag);
    endtask

    task automatic reboot(input string tag);
        boot_req = 1'b1;
        @(posedge clk); #1;
        boot_req = 1'b0;
        checkEq({tag, ".reboot.cpu_reset"}, cpu_reset, 1'b1);
        checkEq({tag, ".reboot.busy"}, busy, 1'b1);
        checkEq({tag, ".reboot.done"}, done, 1'b0);
        checkEq({tag, ".reboot.error"}, error, 1'b0);
        checkEq({tag, ".reboot.rx_ready"}, rx_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        boot_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        reset = 1'b1;

        // boot_req held during the whole load must be ignored
        curWords = '{16'h1234, 16'hABCD, 16'h0001};
        boot_req = 1'b1;
        loadAndCheck("nominal", 16'hBE02, 0);
        reboot("nominal");

        loadAndCheck("badChk", 16'hBE03, 0);
        reboot("badChk");
        loadAndCheck("recover", 16'hBE02, 0);
        reboot("recover");

        curWords.delete();
        loadAndCheck("empty", 16'h0000, 0);
        reboot("empty");

        obsWrites.delete();
        txBytes = '{8'h01, 8'h80};
        sendBytes(0, "oversize");
        checkEq("oversize.error", error, 1'b1);
        checkEq("oversize.done", done, 1'b0);
        checkEq("oversize.cpu_reset", cpu_reset, 1'b1);
        checkEq("oversize.busy", busy, 1'b0);
        checkEq("oversize.rx_ready", rx_ready, 1'b0);
        @(negedge clk); #1;
        checkEq("oversize.writeCount", obsWrites.size(), 0);
        reboot("oversize");

        // full-capacity length is legal; abort it with a reset afterwards
        txBytes = '{8'h00, 8'h80};
        sendBytes(0, "maxLen");
        checkEq("maxLen.error", error, 1'b0);
        checkEq("maxLen.busy", busy, 1'b1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        checkResetValues("maxLenReset");

        curWords = '{16'h1234, 16'hABCD, 16'h0001};
        loadAndCheck("throttled", 16'hBE02, 5);
        reboot("throttled");

        curWords = '{16'hFFFF, 16'h0002};
        loadAndCheck("wrap", 16'h0001, 0);
        reboot("wrap");

        for (int t = 0; t < 8; t++) begin
            logic [15:0] chk;
            int n;
            n = $urandom_range(10, 1);
            curWords.delete();
            for (int k = 0; k < n; k++) curWords.push_back(16'($urandom));
            chk = imageSum();
            if ($urandom_range(1, 0) == 1) chk = chk ^ (16'h0001 << $urandom_range(15, 0));
            loadAndCheck($sformatf("rand%0d", t), chk, $urandom_range(3, 0));
            reboot($sformatf("rand%0d", t));
        end

        curWords.delete();
        for (int k = 0; k < 4; k++) curWords.push_back(16'($urandom));
        expWrites.delete();
        for (int k = 0; k < 2; k++) expWrites.push_back({1'b0, 15'(k), curWords[k]});
        obsWrites.delete();
        buildStream(16'd4, imageSum());
        while (txBytes.size() > 6) void'(txBytes.pop_back());
        sendBytes(0, "midReset");
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        reset    = 1'b0;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        reset    = 1'b1;
        checkResetValues("midReset");
        repeat (3) @(negedge clk);
        #1;
        compareWrites("midReset");

        for (int k = 0; k < 4; k++) curWords[k] = 16'($urandom);
        loadAndCheck("afterReset", imageSum(), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
